// File: rtl/soc_system_sysid_pkg.sv
// ---------------------------------------------------------------------------
// soc_system_sysid_pkg
// Shared types and constants for the system-ID checker:
//   sysid_state_e  - checker FSM states
//   ADDR_ID/ADDR_TS - sysid slave word addresses (ID word, build timestamp)
//   sysid_word_t   - 32-bit sysid data word
//   check_pass()   - pass/fail verdict from the two word compares
// ---------------------------------------------------------------------------
package soc_system_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ID   = 3'd1,
        WAIT_ID = 3'd2,
        RD_TS   = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } sysid_state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef logic [31:0] sysid_word_t;

    // The timestamp only matters when the build asks for it to be checked.
    function automatic logic check_pass(input logic id_ok,
                                        input logic ts_ok,
                                        input logic check_ts);
        return id_ok & (ts_ok | ~check_ts);
    endfunction

endpackage

// File: rtl/soc_system_sysid_rd_ctl.sv
// ---------------------------------------------------------------------------
// soc_system_sysid_rd_ctl
// Single-read engine for the sysid Avalon-MM port, reused for both words.
// The owning FSM says which phase it is in; this block produces the read
// strobe, the accept pulse, the data-valid (capture) pulse after the read
// latency, and an optional stall timeout.
//
// Optional feature: SYSID_CHECK_TIMEOUT_EN enables the waitrequest stall
// counter; without it stall_timeout is constant 0.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   rd_active         owner is in a RD_* state (read strobe phase)
//   wait_active       owner is in a WAIT_* state (latency countdown phase)
//   avm_waitrequest   slave stall
//   avm_read          read strobe
//   accept            read accepted this cycle
//   data_valid        readdata valid this cycle (capture it)
//   stall_timeout     read stalled TIMEOUT_CYCLES cycles (this cycle is the last)
// ---------------------------------------------------------------------------
module soc_system_sysid_rd_ctl #(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic rd_active,
    input  logic wait_active,
    input  logic avm_waitrequest,
    output logic avm_read,
    output logic accept,
    output logic data_valid,
    output logic stall_timeout
);

    // Strobe is purely a decode of the owner's state, so an asynchronous
    // reset of that state drops the read immediately.
    assign avm_read = rd_active;
    assign accept   = rd_active & ~avm_waitrequest;

    generate
        if (READ_LATENCY == 0) begin : g_no_lat
            // Data arrives with the accept; no countdown needed.
            logic unused_lat_inputs;
            assign unused_lat_inputs = ^{wait_active, clock, reset};
            assign data_valid = accept;
        end else begin : g_lat
            localparam int LAT_W = $clog2(READ_LATENCY + 1);
            logic [LAT_W-1:0] lat_cnt;

            // Loaded with the full latency on accept; data is valid in the
            // wait cycle where the count has run down to 1.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    lat_cnt <= '0;
                end else if (accept) begin
                    lat_cnt <= LAT_W'(READ_LATENCY);
                end else if (wait_active && (lat_cnt != '0)) begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end

            assign data_valid = wait_active && (lat_cnt == LAT_W'(1));
        end
    endgenerate

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] stall_cnt;
    logic            stalling;

    assign stalling = rd_active & avm_waitrequest;

    // Counts completed stall cycles of the current read; any non-stall
    // cycle (accept or no read) restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stalling) begin
            stall_cnt <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

    assign stall_timeout = stalling && (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: rtl/soc_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// soc_system_sysid_checker
// Avalon-MM master that reads the sysid slave (word 0 = ID, word 1 = build
// timestamp), compares both against the expected values and publishes sticky
// done/pass status for the HPS/LED status logic.
//
// Optional feature: SYSID_CHECK_TIMEOUT_EN adds a waitrequest stall timeout
// (TIMEOUT_CYCLES); without it a read waits indefinitely and timeout is 0.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   start             one-cycle pulse, launches a check from IDLE
//   avm_address       sysid word select (0 = ID, 1 = timestamp)
//   avm_read          read strobe
//   avm_waitrequest   slave stall
//   avm_readdata      sysid read data
//   busy              check in progress
//   done              sticky, a check has completed
//   pass              sticky, verdict of the last completed check
//   id_value          captured ID word
//   ts_value          captured timestamp word
//   timeout           sticky, a read stalled too long
// ---------------------------------------------------------------------------
module soc_system_sysid_checker
    import soc_system_sysid_pkg::*;
#(
    parameter sysid_word_t EXPECTED_ID    = 32'hACD51302,
    parameter sysid_word_t EXPECTED_TS    = 32'h566B08A5,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          READ_LATENCY   = 0,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        timeout
);

    sysid_state_e state;
    sysid_state_e next_state;

    logic auto_pending;
    logic launch;
    logic rd_active;
    logic wait_active;
    logic accept;
    logic data_valid;
    logic timeout_hit;
    logic cap_id;
    logic cap_ts;

    // Set by reset, consumed by the first clock after release, so the
    // automatic check starts exactly once per reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            auto_pending <= AUTO_START;
        end else begin
            auto_pending <= 1'b0;
        end
    end

    // A start outside IDLE (including the DONE cycle) is dropped, not queued.
    assign launch = (state == IDLE) && (start || auto_pending);

    assign rd_active   = (state == RD_ID)   || (state == RD_TS);
    assign wait_active = (state == WAIT_ID) || (state == WAIT_TS);

    // Address decodes from state, so it holds steady for a whole stalled read.
    assign avm_address = ((state == RD_TS) || (state == WAIT_TS)) ? ADDR_TS : ADDR_ID;
    assign busy        = (state != IDLE);

    soc_system_sysid_rd_ctl #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_ctl (
        .clock           (clock),
        .reset           (reset),
        .rd_active       (rd_active),
        .wait_active     (wait_active),
        .avm_waitrequest (avm_waitrequest),
        .avm_read        (avm_read),
        .accept          (accept),
        .data_valid      (data_valid),
        .stall_timeout   (timeout_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = RD_ID;
                end
            end
            RD_ID: begin
                if (timeout_hit) begin
                    next_state = IDLE;
                end else if (accept) begin
                    next_state = (READ_LATENCY == 0) ? RD_TS : WAIT_ID;
                end
            end
            WAIT_ID: begin
                if (data_valid) begin
                    next_state = RD_TS;
                end
            end
            RD_TS: begin
                if (timeout_hit) begin
                    next_state = IDLE;
                end else if (accept) begin
                    next_state = (READ_LATENCY == 0) ? DONE : WAIT_TS;
                end
            end
            WAIT_TS: begin
                if (data_valid) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // data_valid only fires inside the matching read/wait pair, so the
    // address tells which word is on the bus.
    assign cap_id = data_valid && (avm_address == ADDR_ID);
    assign cap_ts = data_valid && (avm_address == ADDR_TS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (cap_id) begin
                id_value <= avm_readdata;
            end
            if (cap_ts) begin
                ts_value <= avm_readdata;
            end
        end
    end

    // Both words are registered by the time DONE is reached, so the verdict
    // compares the captured copies.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (launch) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else if (state == DONE) begin
            done <= 1'b1;
            pass <= check_pass(id_value == EXPECTED_ID,
                               ts_value == EXPECTED_TS,
                               CHECK_TS);
        end else if (timeout_hit) begin
            done <= 1'b1;
            pass <= 1'b0;
        end
    end

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (launch) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_soc_system_sysid_checker
// Two checker instances share clock and reset:
//   dut_a : defaults (READ_LATENCY=0, CHECK_TS=1, AUTO_START=1)
//   dut_b : READ_LATENCY=2, CHECK_TS=0, AUTO_START=1
// Slave models return the word for the current address only in the cycle the
// data is valid, and 0xDEADBEEF otherwise, so mistimed captures show up.
// ---------------------------------------------------------------------------
module tb_soc_system_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'hACD51302;
    localparam logic [31:0] GOOD_TS = 32'h566B08A5;
    localparam logic [31:0] JUNK    = 32'hDEADBEEF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [31:0] slave_id;
    logic [31:0] slave_ts;

    logic        start_a, wr_a, address_a, read_a, busy_a, done_a, pass_a, timeout_a;
    logic [31:0] readdata_a, id_a, ts_a;
    logic        start_b, wr_b, address_b, read_b, busy_b, done_b, pass_b, timeout_b;
    logic [31:0] readdata_b, id_b, ts_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Zero-latency slave: data only in the accept cycle.
    assign readdata_a = (read_a && !wr_a) ? (address_a ? slave_ts : slave_id) : JUNK;

    // Two-cycle-latency slave: data only two cycles after the accept cycle.
    logic acc_b1, acc_b2, addr_b1, addr_b2;
    always @(posedge clock) begin
        acc_b1  <= read_b & ~wr_b;
        addr_b1 <= address_b;
        acc_b2  <= acc_b1;
        addr_b2 <= addr_b1;
    end
    assign readdata_b = (acc_b2 === 1'b1) ? (addr_b2 ? slave_ts : slave_id) : JUNK;

    soc_system_sysid_checker #(
        .TIMEOUT_CYCLES (8)
    ) dut_a (
        .clock           (clock),
        .reset           (reset),
        .start           (start_a),
        .avm_address     (address_a),
        .avm_read        (read_a),
        .avm_waitrequest (wr_a),
        .avm_readdata    (readdata_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .id_value        (id_a),
        .ts_value        (ts_a),
        .timeout         (timeout_a)
    );

    soc_system_sysid_checker #(
        .CHECK_TS       (1'b0),
        .READ_LATENCY   (2),
        .TIMEOUT_CYCLES (8)
    ) dut_b (
        .clock           (clock),
        .reset           (reset),
        .start           (start_b),
        .avm_address     (address_b),
        .avm_read        (read_b),
        .avm_waitrequest (wr_b),
        .avm_readdata    (readdata_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .id_value        (id_b),
        .ts_value        (ts_b),
        .timeout         (timeout_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Outputs while reset is held.
    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({read_a, address_a, busy_a, done_a, pass_a, timeout_a} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_a: got %b required 000000",
                     {read_a, address_a, busy_a, done_a, pass_a, timeout_a});
        end
        n_checks++;
        if ({id_a, ts_a} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_words_a: got %h/%h required 0/0", id_a, ts_a);
        end
        n_checks++;
        if ({read_b, busy_b, done_b, pass_b} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_b: got %b required 0000", {read_b, busy_b, done_b, pass_b});
        end
        reset = 1'b0;
    endtask

    // Auto-start after reset release. dut_a: RD_ID, RD_TS, DONE, then done
    // visible after the 4th edge. dut_b (latency 2): RD_ID, 2x WAIT_ID,
    // RD_TS, 2x WAIT_TS, DONE -> done visible after the 8th edge.
    task automatic test_zero_wait();
        int reads = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            reads += int'(read_a);
            if (i == 3) begin
                n_checks++;
                if (done_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zw_done_early: got %b required 0", done_a);
                end
            end
            if (i == 4) begin
                n_checks++;
                if ({done_a, pass_a, busy_a} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL zw_done_pass: done/pass/busy got %b required 110",
                             {done_a, pass_a, busy_a});
                end
                n_checks++;
                if (id_a !== GOOD_ID || ts_a !== GOOD_TS) begin
                    n_fail++;
                    $display("FAIL zw_words: got %h/%h required %h/%h", id_a, ts_a, GOOD_ID, GOOD_TS);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (done_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat_done_early: got %b required 0", done_b);
                end
            end
        end
        n_checks++;
        if (reads != 2) begin
            n_fail++;
            $display("FAIL zw_read_cycles: got %0d required 2", reads);
        end
        n_checks++;
        if ({done_b, pass_b} !== 2'b11 || id_b !== GOOD_ID || ts_b !== GOOD_TS) begin
            n_fail++;
            $display("FAIL lat_auto: done/pass %b id %h ts %h required 11 %h %h",
                     {done_b, pass_b}, id_b, ts_b, GOOD_ID, GOOD_TS);
        end
    endtask

    // Wrong ID / wrong timestamp with CHECK_TS=1, wrong timestamp with CHECK_TS=0.
    task automatic test_mismatch();
        int cyc;
        slave_id = 32'hACD51303;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_checks++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL id_bad_clear: done got %b required 0", done_a);
        end
        repeat (3) tick();
        n_checks++;
        if ({done_a, pass_a} !== 2'b10 || id_a !== 32'hACD51303) begin
            n_fail++;
            $display("FAIL id_bad: done/pass %b id %h required 10 acd51303", {done_a, pass_a}, id_a);
        end
        slave_id = GOOD_ID;

        slave_ts = 32'h566B08A4;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({done_a, pass_a} !== 2'b10 || ts_a !== 32'h566B08A4) begin
            n_fail++;
            $display("FAIL ts_bad: done/pass %b ts %h required 10 566b08a4", {done_a, pass_a}, ts_a);
        end

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != 7) begin
            n_fail++;
            $display("FAIL ts_off_latency: done after %0d cycles required 7", cyc);
        end
        n_checks++;
        if (pass_b !== 1'b1 || ts_b !== 32'h566B08A4) begin
            n_fail++;
            $display("FAIL ts_off_pass: pass %b ts %h required 1 566b08a4", pass_b, ts_b);
        end
        slave_ts = GOOD_TS;
    endtask

    // dut_b, waitrequest high for 3 cycles on each read, then accept.
    // Per word: 3 stall + 1 accept + 2 wait cycles; then DONE, so done is
    // visible 2*6 + 1 = 13 edges after the start edge (14 edges inclusive).
    task automatic test_stall_latency();
        int cyc = 0, stalls = 0, stable_err = 0, read_cycles = 0, ts_reads = 0;
        logic p_read, p_wr, p_addr;
        start_b = 1'b1;
        wr_b    = 1'b1;
        tick();
        start_b = 1'b0;
        while (done_b !== 1'b1 && cyc < 40) begin
            if (read_b) begin
                read_cycles++;
                if (address_b) ts_reads++;
                if (stalls < 3) begin
                    wr_b = 1'b1;
                    stalls++;
                end else begin
                    wr_b = 1'b0;
                end
            end else begin
                wr_b   = 1'b1;
                stalls = 0;
            end
            p_read = read_b;
            p_wr   = wr_b;
            p_addr = address_b;
            tick();
            cyc++;
            if (p_read && p_wr && (read_b !== 1'b1 || address_b !== p_addr)) stable_err++;
        end
        wr_b = 1'b0;
        n_checks++;
        if (cyc != 13) begin
            n_fail++;
            $display("FAIL stall_done_cycle: got %0d required 13", cyc);
        end
        n_checks++;
        if (read_cycles != 8 || ts_reads != 4) begin
            n_fail++;
            $display("FAIL stall_read_cycles: got %0d (ts %0d) required 8 (ts 4)", read_cycles, ts_reads);
        end
        n_checks++;
        if (stable_err != 0) begin
            n_fail++;
            $display("FAIL stall_stable: %0d unstable stall cycles required 0", stable_err);
        end
        n_checks++;
        if (pass_b !== 1'b1 || id_b !== GOOD_ID || ts_b !== GOOD_TS) begin
            n_fail++;
            $display("FAIL stall_capture: pass %b id %h ts %h required 1 %h %h", pass_b, id_b, ts_b, GOOD_ID, GOOD_TS);
        end
    endtask

    // start while busy and in the DONE cycle is dropped; start in IDLE reruns.
    task automatic test_start_ignored();
        start_a = 1'b1;
        tick();             // RD_ID, start still high while busy
        tick();             // RD_TS
        start_a = 1'b0;
        tick();             // DONE
        start_a = 1'b1;
        tick();             // IDLE, done set
        start_a = 1'b0;
        n_checks++;
        if ({busy_a, done_a, pass_a} !== 3'b011) begin
            n_fail++;
            $display("FAIL busy_start_done: busy/done/pass got %b required 011", {busy_a, done_a, pass_a});
        end
        tick();
        n_checks++;
        if (busy_a !== 1'b0 || read_a !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle_start: busy/read got %b required 00", {busy_a, read_a});
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_checks++;
        if ({busy_a, done_a, pass_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL restart_clear: busy/done/pass got %b required 100", {busy_a, done_a, pass_a});
        end
        repeat (3) tick();
        n_checks++;
        if ({busy_a, done_a, pass_a} !== 3'b011) begin
            n_fail++;
            $display("FAIL restart_done: busy/done/pass got %b required 011", {busy_a, done_a, pass_a});
        end
    endtask

    // Reset mid-check: dut_a stalled in RD_ID, dut_b in WAIT_TS.
    task automatic test_reset_mid();
        wr_a    = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (4) tick();
        n_checks++;
        if ({read_a, busy_b, address_b, read_b} !== 4'b1110) begin
            n_fail++;
            $display("FAIL pre_reset_state: read_a/busy_b/addr_b/read_b got %b required 1110",
                     {read_a, busy_b, address_b, read_b});
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({read_a, busy_a, done_a, pass_a, address_a} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset_a: got %b required 00000", {read_a, busy_a, done_a, pass_a, address_a});
        end
        n_checks++;
        if ({busy_b, done_b, pass_b} !== 3'b0 || id_b !== 32'h0 || ts_b !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_b: ctl %b id %h ts %h required 000 0 0", {busy_b, done_b, pass_b}, id_b, ts_b);
        end
        tick();
        reset = 1'b0;
        wr_a  = 1'b0;
        repeat (4) tick();
        n_checks++;
        if ({done_a, pass_a} !== 2'b11 || id_a !== GOOD_ID) begin
            n_fail++;
            $display("FAIL rerun_a: done/pass %b id %h required 11 %h", {done_a, pass_a}, id_a, GOOD_ID);
        end
        repeat (4) tick();
        n_checks++;
        if ({done_b, pass_b} !== 2'b11 || ts_b !== GOOD_TS) begin
            n_fail++;
            $display("FAIL rerun_b: done/pass %b ts %h required 11 %h", {done_b, pass_b}, ts_b, GOOD_TS);
        end
    endtask

`ifdef SYSID_CHECK_TIMEOUT_EN
    // waitrequest stuck: 8 stall cycles, then read drops with timeout/done set.
    task automatic test_timeout();
        wr_a    = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_checks++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: done got %b required 0", done_a);
        end
        repeat (7) tick();
        n_checks++;
        if ({read_a, timeout_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_early: read/timeout got %b required 10", {read_a, timeout_a});
        end
        tick();
        n_checks++;
        if ({timeout_a, done_a, pass_a, read_a, busy_a} !== 5'b11000) begin
            n_fail++;
            $display("FAIL to_hit: timeout/done/pass/read/busy got %b required 11000",
                     {timeout_a, done_a, pass_a, read_a, busy_a});
        end
        wr_a = 1'b0;
    endtask
`else
    // Without the timeout feature a stuck slave holds the read indefinitely.
    task automatic test_timeout();
        wr_a    = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (20) tick();
        n_checks++;
        if ({read_a, busy_a, address_a, timeout_a, done_a} !== 5'b11000) begin
            n_fail++;
            $display("FAIL no_timeout_hold: read/busy/addr/timeout/done got %b required 11000",
                     {read_a, busy_a, address_a, timeout_a, done_a});
        end
    endtask
`endif

    initial begin
        slave_id = GOOD_ID;
        slave_ts = GOOD_TS;
        start_a  = 1'b0;
        start_b  = 1'b0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        test_reset();
        test_zero_wait();
        test_mismatch();
        test_stall_latency();
        test_start_ignored();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
